ram_access_ctrl: RTL and testbench

//  Command sequencer that sits directly upstream of RAM_SINGLE_PORT. It accepts
//  one read/write command at a time over a valid/ready handshake and drives the
//  RAM strobes (blk_select, addr_en, wr_en, rd_en, dout_en) in the order that the
//  RAM pipeline configuration requires. It returns read data with a parity check

---
 rtl/ram_access_ctrl.sv | 104 ++++++++++
 tb/tb_ram_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Single-command sequencer in front of RAM_SINGLE_PORT: walks the RAM strobes
// through the pipeline phases the RAM is configured for and returns read data.
module ram_access_ctrl #(
  parameter int    MEM_WIDTH     = 16,
  parameter int    ADDR_SIZE     = 10,
  parameter string ADDR_PIPELINE = "FALSE",
  parameter string DOUT_PIPELINE = "TRUE",
  parameter int    PARITY_ENABLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [MEM_WIDTH-1:0] cmd_data,
  output logic                 ram_blk_select,
  output logic                 ram_addr_en,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_dout_en,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity_out,
  output logic                 wr_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic                 rsp_parity_err
);
  localparam bit A_P = (ADDR_PIPELINE == "TRUE");
  localparam bit D_P = (DOUT_PIPELINE == "TRUE");

  typedef enum logic [2:0] {IDLE, ADDR, ACC, DOUT, CAP, RESP} state_t;
  state_t state, state_nxt;
  logic   wr_q;
  logic   accept;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Strobes are pure state decode so the RAM sees glitch-free Moore outputs.
  always_comb begin
    state_nxt      = state;
    ram_blk_select = 1'b0;
    ram_addr_en    = 1'b0;
    ram_wr_en      = 1'b0;
    ram_rd_en      = 1'b0;
    ram_dout_en    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = A_P ? ADDR : ACC;
      ADDR: begin
        ram_blk_select = 1'b1;
        ram_addr_en    = 1'b1;
        state_nxt      = ACC;
      end
      ACC: begin
        ram_blk_select = 1'b1;
        ram_wr_en      = wr_q;
        ram_rd_en      = !wr_q;
        state_nxt      = wr_q ? IDLE : (D_P ? DOUT : CAP);
      end
      DOUT: begin
        ram_dout_en = 1'b1;
        state_nxt   = CAP;
      end
      CAP:  state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q           <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= '0;
      wr_done        <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_parity_err <= 1'b0;
    end else begin
      if (accept) begin
        wr_q     <= cmd_wr;
        ram_addr <= cmd_addr;
        ram_din  <= cmd_data;
      end
      wr_done <= (state == ACC) && wr_q;
      if (state == CAP) begin
        rsp_data       <= ram_dout;
        rsp_parity_err <= (PARITY_ENABLE != 0) ? (ram_parity_out ^ (^ram_dout)) : 1'b0;
        rsp_valid      <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: five instances (four A/D pipeline combos plus a
// parity-disabled one), each in front of a small behavioural single-port RAM.
module tb_ram_access_ctrl;
  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid[NI], cmd_wr[NI], rsp_ready[NI], inj[NI];
  logic [9:0]  cmd_addr[NI];
  logic [15:0] cmd_data[NI];
  logic        cmd_ready[NI], ram_blk_select[NI], ram_addr_en[NI], ram_wr_en[NI];
  logic        ram_rd_en[NI], ram_dout_en[NI], ram_parity_out[NI];
  logic        wr_done[NI], rsp_valid[NI], rsp_parity_err[NI];
  logic [9:0]  ram_addr[NI];
  logic [15:0] ram_din[NI], ram_dout[NI], rsp_data[NI];

  // Instance map: 0 A0D0, 1 A0D1 (defaults), 2 A1D0, 3 A1D1, 4 A0D1 parity off
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam bit A = (g == 2) || (g == 3);
    localparam bit D = (g == 1) || (g == 3) || (g == 4);
    ram_access_ctrl #(
      .MEM_WIDTH(16), .ADDR_SIZE(10),
      .ADDR_PIPELINE(A ? "TRUE" : "FALSE"),
      .DOUT_PIPELINE(D ? "TRUE" : "FALSE"),
      .PARITY_ENABLE(g == 4 ? 0 : 1)
    ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_wr(cmd_wr[g]),
      .cmd_addr(cmd_addr[g]), .cmd_data(cmd_data[g]),
      .ram_blk_select(ram_blk_select[g]), .ram_addr_en(ram_addr_en[g]),
      .ram_wr_en(ram_wr_en[g]), .ram_rd_en(ram_rd_en[g]), .ram_dout_en(ram_dout_en[g]),
      .ram_addr(ram_addr[g]), .ram_din(ram_din[g]), .ram_dout(ram_dout[g]),
      .ram_parity_out(ram_parity_out[g]), .wr_done(wr_done[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_data(rsp_data[g]), .rsp_parity_err(rsp_parity_err[g])
    );

    // Behavioural RAM: optional address register, read register, optional dout register
    logic [15:0] mem [1024];
    logic [9:0]  areg;
    logic [15:0] rreg, dreg;
    logic [9:0]  aeff;
    assign aeff = A ? areg : ram_addr[g];
    always_ff @(posedge clk) begin
      if (ram_addr_en[g]) areg <= ram_addr[g];
      if (ram_blk_select[g] && ram_wr_en[g]) mem[aeff] <= ram_din[g];
      if (ram_blk_select[g] && ram_rd_en[g]) rreg <= mem[aeff];
      if (ram_dout_en[g]) dreg <= rreg;
    end
    assign ram_dout[g]       = D ? dreg : rreg;
    assign ram_parity_out[g] = (^ram_dout[g]) ^ inj[g];
  end

  // Reference: plain memory image per instance plus the latency rule 2+A+D / 1+A
  logic [15:0] ref_mem [NI][1024];
  function automatic int a_of(input int i); return (i == 2 || i == 3) ? 1 : 0; endfunction
  function automatic int d_of(input int i); return (i == 1 || i == 3 || i == 4) ? 1 : 0; endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input int i, input bit wr, input logic [9:0] addr, input logic [15:0] data,
                        input logic [15:0] exp, input bit exp_perr, input int hold);
    int lat;
    int exp_lat;
    bit saw_aen, saw_den;
    lat     = -1;
    exp_lat = wr ? 1 + a_of(i) : 2 + a_of(i) + d_of(i);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready[i], 1);
    cmd_valid[i] = 1; cmd_wr[i] = wr; cmd_addr[i] = addr; cmd_data[i] = data;
    @(posedge clk); #1;
    cmd_valid[i] = 0;
    chk("cmd_ready_busy", cmd_ready[i], 0);
    saw_aen = ram_addr_en[i];
    saw_den = ram_dout_en[i];
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      saw_aen |= ram_addr_en[i];
      saw_den |= ram_dout_en[i];
      if (wr ? wr_done[i] : rsp_valid[i]) begin
        lat = c;
        break;
      end
    end
    chk(wr ? "wr_latency" : "rd_latency", lat, exp_lat);
    chk("addr_en_seen", saw_aen, a_of(i));
    chk("dout_en_seen", saw_den, (!wr && d_of(i) == 1) ? 1 : 0);
    if (lat < 0) return;
    if (wr) begin
      ref_mem[i][addr] = data;
      chk("wr_ready_after", cmd_ready[i], 1);
      @(posedge clk); #1;
      chk("wr_done_pulse", wr_done[i], 0);
    end else begin
      chk("rsp_data", rsp_data[i], exp);
      chk("rsp_parity_err", rsp_parity_err[i], exp_perr);
      // a conflicting write offered while the response is held must be ignored
      if (hold > 0) begin
        cmd_valid[i] = 1; cmd_wr[i] = 1; cmd_addr[i] = addr; cmd_data[i] = ~exp;
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_valid", rsp_valid[i], 1);
        chk("hold_data", rsp_data[i], exp);
        chk("hold_ready", cmd_ready[i], 0);
        chk("hold_blk", ram_blk_select[i], 0);
      end
      cmd_valid[i] = 0;
      rsp_ready[i] = 1;
      @(posedge clk); #1;
      rsp_ready[i] = 0;
      chk("rsp_consumed", rsp_valid[i], 0);
      chk("ready_after_rsp", cmd_ready[i], 1);
    end
  endtask

  typedef struct {
    int          inst;
    bit          wr;
    logic [9:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    bit          inj;
    bit          perr;
    int          hold;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] pool [8];
    logic [9:0] a;
    tbl[0] = '{1, 1, 10'd3,   16'hA5A5, 16'h0000, 0, 0, 0};
    tbl[1] = '{1, 0, 10'd3,   16'h0000, 16'hA5A5, 0, 0, 0};
    tbl[2] = '{1, 1, 10'd9,   16'h0001, 16'h0000, 0, 0, 0};
    tbl[3] = '{1, 0, 10'd9,   16'h0000, 16'h0001, 0, 0, 0};
    tbl[4] = '{1, 0, 10'd9,   16'h0000, 16'h0001, 1, 1, 0};
    tbl[5] = '{4, 1, 10'd9,   16'h0001, 16'h0000, 0, 0, 0};
    tbl[6] = '{4, 0, 10'd9,   16'h0000, 16'h0001, 1, 0, 0};
    tbl[7] = '{1, 0, 10'd3,   16'h0000, 16'hA5A5, 0, 0, 5};
    tbl[8] = '{1, 0, 10'd3,   16'h0000, 16'hA5A5, 0, 0, 0};
    tbl[9] = '{1, 1, 10'h3FF, 16'hFFFF, 16'h0000, 0, 0, 0};

    for (int i = 0; i < NI; i++) begin
      cmd_valid[i] = 0; cmd_wr[i] = 0; cmd_addr[i] = '0; cmd_data[i] = '0;
      rsp_ready[i] = 0; inj[i] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blk", ram_blk_select[1], 0);
    chk("rst_strobes", {ram_addr_en[1], ram_wr_en[1], ram_rd_en[1], ram_dout_en[1]}, 0);
    chk("rst_addr", ram_addr[1], 0);
    chk("rst_din", ram_din[1], 0);
    chk("rst_wr_done", wr_done[1], 0);
    chk("rst_rsp_valid", rsp_valid[1], 0);
    chk("rst_rsp_data", rsp_data[1], 0);
    chk("rst_perr", rsp_parity_err[1], 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("rst_ready", cmd_ready[1], 1);

    // Directed vectors: defaults, parity on/off, backpressure, top address
    for (int k = 0; k < 10; k++) begin
      inj[tbl[k].inst] = tbl[k].inj;
      do_cmd(tbl[k].inst, tbl[k].wr, tbl[k].addr, tbl[k].data, tbl[k].exp, tbl[k].perr, tbl[k].hold);
      inj[tbl[k].inst] = 0;
    end

    // Back-to-back writes: cmd_ready alternates while cmd_valid stays high
    @(negedge clk);
    cmd_valid[1] = 1; cmd_wr[1] = 1; cmd_addr[1] = 10'd5; cmd_data[1] = 16'h1111;
    chk("b2b_ready0", cmd_ready[1], 1);
    @(negedge clk);
    chk("b2b_ready1", cmd_ready[1], 0);
    cmd_data[1] = 16'h2222;
    @(negedge clk);
    chk("b2b_ready2", cmd_ready[1], 1);
    @(negedge clk);
    chk("b2b_ready3", cmd_ready[1], 0);
    cmd_valid[1] = 0;
    ref_mem[1][5] = 16'h2222;
    do_cmd(1, 0, 10'd5, 16'h0, 16'h2222, 0, 0);

    // Randomized traffic on every configuration, including addresses 0 and 1023
    for (int i = 0; i < NI; i++) begin
      pool[0] = 10'd0;
      pool[1] = 10'h3FF;
      for (int k = 2; k < 8; k++) pool[k] = 10'($urandom_range(1022, 1));
      for (int k = 0; k < 8; k++) do_cmd(i, 1, pool[k], 16'($urandom), 16'h0, 0, 0);
      for (int n = 0; n < 25; n++) begin
        a = pool[$urandom_range(7)];
        if ($urandom_range(1) == 1) do_cmd(i, 1, a, 16'($urandom), 16'h0, 0, 0);
        else                        do_cmd(i, 0, a, 16'h0, ref_mem[i][a], 0, $urandom_range(2));
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(i, 0, 10'd0,   16'h0, ref_mem[i][0], 0, 0);
      do_cmd(i, 0, 10'h3FF, 16'h0, ref_mem[i][1023], 0, 0);
    end

    // Reset while a read sits in ACC
    @(negedge clk);
    cmd_valid[1] = 1; cmd_wr[1] = 0; cmd_addr[1] = 10'd3;
    @(posedge clk); #1;
    cmd_valid[1] = 0;
    chk("acc_rd_en", ram_rd_en[1], 1);
    rst = 1; #1;
    chk("acc_rst_strobes", {ram_blk_select[1], ram_addr_en[1], ram_wr_en[1], ram_rd_en[1], ram_dout_en[1]}, 0);
    chk("acc_rst_valid", rsp_valid[1], 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("acc_rst_ready", cmd_ready[1], 1);
    chk("acc_rst_valid2", rsp_valid[1], 0);

    // Reset while a response is pending
    @(negedge clk);
    cmd_valid[1] = 1; cmd_wr[1] = 0; cmd_addr[1] = 10'd3;
    @(posedge clk); #1;
    cmd_valid[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("resp_pending", rsp_valid[1], 1);
    rst = 1; #1;
    chk("resp_rst_valid", rsp_valid[1], 0);
    chk("resp_rst_data", rsp_data[1], 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("resp_rst_ready", cmd_ready[1], 1);
    chk("resp_rst_blk", ram_blk_select[1], 0);

    // Write aborted in ADDR (A=1) is not committed
    do_cmd(2, 1, 10'd3, 16'h1234, 16'h0, 0, 0);
    @(negedge clk);
    cmd_valid[2] = 1; cmd_wr[2] = 1; cmd_addr[2] = 10'd3; cmd_data[2] = 16'hBEEF;
    @(posedge clk); #1;
    cmd_valid[2] = 0;
    chk("abort_addr_en", ram_addr_en[2], 1);
    rst = 1; #1;
    chk("abort_strobes", {ram_blk_select[2], ram_addr_en[2], ram_wr_en[2]}, 0);
    @(negedge clk);
    rst = 0;
    do_cmd(2, 0, 10'd3, 16'h0, 16'h1234, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
